// File: rtl/tdm_demux8x1.sv
// Receive side of the 8:1 TDM link.
// Tracks slot index, collects 8 beats, emits a parallel word.
module tdm_demux8x1 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_start,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [W-1:0] y4,
  output logic [W-1:0] y5,
  output logic [W-1:0] y6,
  output logic [W-1:0] y7,
  output logic         word_valid,
  output logic [2:0]   slot,
  output logic         locked,
  output logic         sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [2:0]   slot_nx;
  logic         wr;
  logic [2:0]   wr_idx;
  logic         done;
  logic         err_nx;
  logic         early;
  logic         missing;
  logic [W-1:0] shadow [7];
  logic [W-1:0] lane [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      slot  <= 3'd0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  assign early   = frame_start && (slot != 3'd0);
  assign missing = !frame_start && (slot == 3'd0);

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    wr       = 1'b0;
    wr_idx   = slot;
    done     = 1'b0;
    err_nx   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_start) begin
            state_nx = SYNC;
            slot_nx  = 3'd1;
            wr       = 1'b1;
            wr_idx   = 3'd0;
          end
        end
        SYNC: begin
          unique case (1'b1)
            early: begin
              // restart the frame on this marker
              err_nx  = 1'b1;
              wr      = 1'b1;
              wr_idx  = 3'd0;
              slot_nx = 3'd1;
            end
            missing: begin
              err_nx   = 1'b1;
              state_nx = HUNT;
              slot_nx  = 3'd0;
            end
            default: begin
              wr      = 1'b1;
              slot_nx = slot + 3'd1;
              done    = (slot == 3'd7);
            end
          endcase
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_comb begin
    locked = (state == SYNC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) shadow[i] <= '0;
    end else if (wr && (wr_idx != 3'd7)) begin
      shadow[wr_idx] <= din;
    end
  end

  // slot 7 goes straight from din into the lane register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) lane[i] <= '0;
      word_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      word_valid <= done;
      sync_err   <= err_nx;
      if (done) begin
        for (int i = 0; i < 7; i++) lane[i] <= shadow[i];
        lane[7] <= din;
      end
    end
  end

  assign y0 = lane[0];
  assign y1 = lane[1];
  assign y2 = lane[2];
  assign y3 = lane[3];
  assign y4 = lane[4];
  assign y5 = lane[5];
  assign y6 = lane[6];
  assign y7 = lane[7];

endmodule

// File: tb/tb_tdm_demux8x1.sv
// Bench for tdm_demux8x1: directed steps then random
// beats, all checked against a frame-level model.
module tb_tdm_demux8x1;

  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic         word_valid;
  logic [2:0]   slot;
  logic         locked;
  logic         sync_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wv = -1;
  int prev_wv = -1;

  bit           m_locked;
  int           m_cnt;
  logic [W-1:0] m_frame [8];
  logic [W-1:0] m_y [8];
  bit           m_wv;
  bit           m_err;

  always #5 clk = ~clk;

  tdm_demux8x1 #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .frame_start(frame_start),
    .y0(y0),
    .y1(y1),
    .y2(y2),
    .y3(y3),
    .y4(y4),
    .y5(y5),
    .y6(y6),
    .y7(y7),
    .word_valid(word_valid),
    .slot(slot),
    .locked(locked),
    .sync_err(sync_err)
  );

  function automatic logic [8*W-1:0] y_obs();
    return {y7, y6, y5, y4, y3, y2, y1, y0};
  endfunction

  function automatic logic [8*W-1:0] y_exp();
    logic [8*W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*W +: W] = m_y[i];
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // frame-level reference: a counter of beats taken
  task automatic model(input bit r, input bit dv,
                       input bit fs,
                       input logic [W-1:0] d);
    if (r) begin
      m_locked = 0;
      m_cnt    = 0;
      m_wv     = 0;
      m_err    = 0;
      for (int i = 0; i < 8; i++) begin
        m_y[i]     = '0;
        m_frame[i] = '0;
      end
      return;
    end
    m_wv  = 0;
    m_err = 0;
    if (!dv) return;
    if (!m_locked) begin
      if (fs) begin
        m_locked   = 1;
        m_frame[0] = d;
        m_cnt      = 1;
      end
    end else if (fs && m_cnt != 0) begin
      m_err      = 1;
      m_frame[0] = d;
      m_cnt      = 1;
    end else if (!fs && m_cnt == 0) begin
      m_err    = 1;
      m_locked = 0;
    end else begin
      m_frame[m_cnt] = d;
      if (m_cnt == 7) begin
        for (int i = 0; i < 8; i++) m_y[i] = m_frame[i];
        m_wv  = 1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input bit r, input bit dv,
                      input bit fs,
                      input logic [W-1:0] d);
    rst         = r;
    din_valid   = dv;
    frame_start = fs;
    din         = d;
    @(posedge clk);
    #1;
    cyc++;
    model(r, dv, fs, d);
    if (word_valid === 1'b1) begin
      prev_wv = last_wv;
      last_wv = cyc;
    end
    chk("y", 64'(y_obs()), 64'(y_exp()));
    chk("word_valid", 64'(word_valid), 64'(m_wv));
    chk("sync_err", 64'(sync_err), 64'(m_err));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("slot", 64'(slot), 64'(m_cnt[2:0]));
  endtask

  task automatic frame(input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      step(0, 1, i == 0, W'(b[i]));
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'b0100_1101;

    // reset with random inputs
    step(1, 1'($urandom), 1'($urandom), W'($urandom));
    step(1, 1'($urandom), 1'($urandom), W'($urandom));
    chk("rst_y", 64'(y_obs()), 64'd0);
    chk("rst_slot", 64'(slot), 64'd0);

    // hunt drops unmarked beats
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, W'($urandom));
    chk("hunt_locked", 64'(locked), 64'd0);

    // clean frame 1,0,1,1,0,0,1,0
    frame(pat);
    chk("clean_y", 64'(y_obs()), 64'(pat));
    chk("clean_wv", 64'(word_valid), 64'd1);
    step(0, 0, 0, '0);
    chk("clean_wv_off", 64'(word_valid), 64'd0);

    // gapped frame
    for (int i = 0; i < 4; i++)
      step(0, 1, i == 0, W'(pat[i]));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, W'($urandom));
      chk("gap_slot", 64'(slot), 64'd4);
    end
    for (int i = 4; i < 8; i++)
      step(0, 1, 0, W'(pat[i]));
    chk("gap_y", 64'(y_obs()), 64'(pat));

    // back-to-back all ones
    frame(8'hff);
    chk("b2b_y", 64'(y_obs()), 64'hff);
    chk("b2b_gap", 64'(last_wv - prev_wv), 64'd8);

    // early marker at slot 5
    for (int i = 0; i < 5; i++)
      step(0, 1, i == 0, W'(i[0]));
    step(0, 1, 1, 1'b0);
    chk("early_err", 64'(sync_err), 64'd1);
    chk("early_y", 64'(y_obs()), 64'hff);
    chk("early_slot", 64'(slot), 64'd1);
    for (int i = 1; i < 8; i++)
      step(0, 1, 0, W'(i[1]));
    chk("early_wv", 64'(word_valid), 64'd1);
    chk("early_data", 64'(y_obs()), 64'b1100_1100);

    // missing marker, then relock
    step(0, 1, 0, 1'b1);
    chk("miss_err", 64'(sync_err), 64'd1);
    chk("miss_locked", 64'(locked), 64'd0);
    step(0, 1, 1, 1'b1);
    chk("relock", 64'(locked), 64'd1);

    // mid-frame reset at slot 4
    for (int i = 1; i < 4; i++)
      step(0, 1, 0, 1'b1);
    chk("pre_rst_slot", 64'(slot), 64'd4);
    step(1, 1, 0, 1'b1);
    chk("mid_rst_y", 64'(y_obs()), 64'd0);
    for (int i = 5; i < 8; i++) begin
      step(0, 1, 0, 1'b1);
      chk("mid_rst_wv", 64'(word_valid), 64'd0);
    end

    // random traffic
    for (int n = 0; n < 800; n++) begin
      bit r, dv, fs;
      r  = ($urandom_range(0, 99) < 2);
      dv = ($urandom_range(0, 99) < 75);
      if (m_cnt == 0)
        fs = ($urandom_range(0, 99) < 90);
      else
        fs = ($urandom_range(0, 99) < 4);
      step(r, dv, fs, W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
